scratch_pad_arbiter: RTL and testbench

SCRATCH_PAD_ARBITER -- requirements
Module: scratch_pad_arbiter

---
 rtl/scratch_pad_arbiter_pkg.sv | 22 ++
 rtl/scratch_pad_arbiter_order_fifo.sv | 62 ++++++
 rtl/scratch_pad_arbiter.sv | 139 +++++++++++++
 tb/tb_scratch_pad_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/scratch_pad_arbiter_pkg.sv
// ============================================================================
//  Module   : scratch_pad_arbiter_pkg
//  Purpose  : Shared helpers for the scratch pad arbiter slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scratch_pad_arbiter_pkg;

    // Ceiling log2, never below 1 so that index fields keep a legal width.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scratch_pad_arbiter_order_fifo.sv
// ============================================================================
//  Module   : order_fifo
//  Purpose  : Records the client index of each outstanding read, in order.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module order_fifo
    import scratch_pad_arbiter_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int C_AW = log2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (C_AW+1)'(DEPTH));
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/scratch_pad_arbiter.sv
// ============================================================================
//  Module   : scratch_pad_arbiter
//  Purpose  : Round-robin sharing of one scratch pad port with ordered reads.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scratch_pad_arbiter
    import scratch_pad_arbiter_pkg::*;
#(
    parameter int REQUESTERS  = 4,
    parameter int WIDTH       = 64,
    parameter int ADDR_WIDTH  = 12,
    parameter int ORDER_DEPTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQUESTERS-1:0]          req_rd_en,
    input  logic [REQUESTERS-1:0]          req_wr_en,
    input  logic [ADDR_WIDTH*REQUESTERS-1:0] req_addr,
    input  logic [WIDTH*REQUESTERS-1:0]    req_d,
    output logic [REQUESTERS-1:0]          req_grant,
    output logic [WIDTH-1:0]               rsp_q,
    output logic [REQUESTERS-1:0]          rsp_valid,
    input  logic [REQUESTERS-1:0]          rsp_stall,
    output logic                           sp_rd_en,
    output logic                           sp_wr_en,
    output logic [ADDR_WIDTH-1:0]          sp_addr,
    output logic [WIDTH-1:0]               sp_d,
    input  logic                           sp_full,
    input  logic [WIDTH-1:0]               sp_q,
    input  logic                           sp_valid,
    output logic                           sp_stall,
    output logic                           error
);

    localparam int C_PTR_W = log2(REQUESTERS);

    logic [C_PTR_W-1:0]    r_rr_ptr;
    logic [C_PTR_W-1:0]    w_win;
    logic                  w_any;
    logic [REQUESTERS-1:0] w_eligible;
    logic [REQUESTERS-1:0] w_grant;
    logic                  w_win_is_wr;
    logic [C_PTR_W-1:0]    w_head;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  r_sp_rd_en;
    logic                  r_sp_wr_en;
    logic [ADDR_WIDTH-1:0] r_sp_addr;
    logic [WIDTH-1:0]      r_sp_d;
    logic                  r_error;

    assign w_pop = sp_valid && !w_fifo_empty && !rsp_stall[w_head];

    // Reads also need an order slot; a same-cycle pop provides one.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            w_eligible[i] = !sp_full && !rst &&
                            (req_wr_en[i] || (req_rd_en[i] && (!w_fifo_full || w_pop)));
        end
    end

    always_comb begin
        int v_idx;
        w_any = 1'b0;
        w_win = '0;
        v_idx = 0;
        for (int k = 0; k < REQUESTERS; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % REQUESTERS;
            if (!w_any && w_eligible[v_idx]) begin
                w_any = 1'b1;
                w_win = C_PTR_W'(v_idx);
            end
        end
    end

    always_comb begin
        w_grant        = '0;
        w_grant[w_win] = w_any;
    end

    assign w_win_is_wr = req_wr_en[w_win];
    assign w_push      = w_any && !w_win_is_wr;
    assign req_grant   = w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_sp_rd_en <= 1'b0;
            r_sp_wr_en <= 1'b0;
            r_sp_addr  <= '0;
            r_sp_d     <= '0;
            r_error    <= 1'b0;
        end else begin
            r_sp_rd_en <= w_push;
            r_sp_wr_en <= w_any && w_win_is_wr;
            if (w_any) begin
                r_rr_ptr  <= (w_win == C_PTR_W'(REQUESTERS-1)) ? '0 : w_win + 1'b1;
                r_sp_addr <= req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                r_sp_d    <= req_d[int'(w_win)*WIDTH +: WIDTH];
            end
            if (sp_valid && w_fifo_empty) r_error <= 1'b1;
        end
    end

    order_fifo #(
        .DEPTH (ORDER_DEPTH),
        .WIDTH (C_PTR_W)
    ) u_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_win),
        .head  (w_head),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    always_comb begin
        rsp_valid         = '0;
        rsp_valid[w_head] = sp_valid && !w_fifo_empty;
    end

    assign rsp_q    = sp_q;
    assign sp_stall = !w_fifo_empty && rsp_stall[w_head];
    assign sp_rd_en = r_sp_rd_en;
    assign sp_wr_en = r_sp_wr_en;
    assign sp_addr  = r_sp_addr;
    assign sp_d     = r_sp_d;
    assign error    = r_error;

endmodule

`default_nettype wire

// File: tb/tb_scratch_pad_arbiter.sv
// ============================================================================
//  Module   : tb_scratch_pad_arbiter
//  Purpose  : Directed self-checking bench for scratch_pad_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scratch_pad_arbiter;

    localparam int R  = 4;
    localparam int W  = 64;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [R-1:0]  req_rd_en, req_wr_en, req_grant, rsp_valid, rsp_stall;
    logic [AW*R-1:0] req_addr;
    logic [W*R-1:0]  req_d;
    logic [W-1:0]  rsp_q, sp_d, sp_q;
    logic          sp_rd_en, sp_wr_en, sp_full, sp_valid, sp_stall, error;
    logic [AW-1:0] sp_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scratch_pad_arbiter #(
        .REQUESTERS(R), .WIDTH(W), .ADDR_WIDTH(AW), .ORDER_DEPTH(32)
    ) dut (
        .clk(clk), .rst(rst), .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
        .req_addr(req_addr), .req_d(req_d), .req_grant(req_grant),
        .rsp_q(rsp_q), .rsp_valid(rsp_valid), .rsp_stall(rsp_stall),
        .sp_rd_en(sp_rd_en), .sp_wr_en(sp_wr_en), .sp_addr(sp_addr), .sp_d(sp_d),
        .sp_full(sp_full), .sp_q(sp_q), .sp_valid(sp_valid), .sp_stall(sp_stall),
        .error(error)
    );

    task automatic idle_inputs();
        req_rd_en = '0; req_wr_en = '0; rsp_stall = '0;
        sp_full = 1'b0; sp_valid = 1'b0; sp_q = '0;
        for (int i = 0; i < R; i++) begin
            req_addr[i*AW +: AW] = AW'(12'h100 + i);
            req_d[i*W +: W]      = W'(64'hD000 + i);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        req_wr_en = 4'b1111;
        #1;
        total++; if (req_grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", req_grant); end
        @(posedge clk); #1;
        total++; if ({sp_rd_en, sp_wr_en} !== 2'b00) begin bad++; $display("FAIL reset_sp_en got=%b exp=00", {sp_rd_en, sp_wr_en}); end
        total++; if (sp_addr !== '0 || sp_d !== '0) begin bad++; $display("FAIL reset_sp_bus got=%h/%h exp=0/0", sp_addr, sp_d); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_read();
        @(negedge clk);
        req_rd_en = 4'b0100;
        req_addr[2*AW +: AW] = 12'h010;
        #1;
        total++; if (req_grant !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b exp=0100", req_grant); end
        @(posedge clk); #1;
        req_rd_en = '0;
        total++; if (sp_rd_en !== 1'b1 || sp_wr_en !== 1'b0 || sp_addr !== 12'h010) begin
            bad++; $display("FAIL single_port got=rd%b wr%b a%h exp=rd1 wr0 a010", sp_rd_en, sp_wr_en, sp_addr); end
        sp_valid = 1'b1; sp_q = 64'hAB;
        #1;
        total++; if (rsp_valid !== 4'b0100 || rsp_q !== 64'hAB) begin
            bad++; $display("FAIL single_rsp got=%b/%h exp=0100/ab", rsp_valid, rsp_q); end
        @(posedge clk); #1;
        idle_inputs();
        total++; if (error !== 1'b0) begin bad++; $display("FAIL single_error got=%b exp=0", error); end
    endtask

    task automatic test_contention();
        logic [R-1:0] exp_g;
        int cnt [R];
        pulse_reset();
        for (int i = 0; i < R; i++) cnt[i] = 0;
        req_wr_en = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_g = 4'b0001 << (c % 4);
            total++; if (req_grant !== exp_g) begin bad++; $display("FAIL rr_grant_c%0d got=%b exp=%b", c, req_grant, exp_g); end
            for (int i = 0; i < R; i++) if (req_grant[i]) cnt[i]++;
            @(posedge clk); #1;
            if (c == 4) begin
                total++; if (sp_wr_en !== 1'b1 || sp_addr !== 12'h100 || sp_d !== 64'hD000) begin
                    bad++; $display("FAIL rr_port_c4 got=wr%b a%h d%h exp=wr1 a100 dd000", sp_wr_en, sp_addr, sp_d); end
            end
            @(negedge clk);
        end
        for (int i = 0; i < R; i++) begin
            total++; if (cnt[i] != 2) begin bad++; $display("FAIL rr_count_%0d got=%0d exp=2", i, cnt[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_full();
        pulse_reset();
        sp_full = 1'b1;
        req_rd_en = 4'b0001;
        req_wr_en = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (req_grant !== 4'b0000) begin bad++; $display("FAIL full_grant_c%0d got=%b exp=0000", c, req_grant); end
            @(posedge clk); #1;
            total++; if ({sp_rd_en, sp_wr_en} !== 2'b00) begin bad++; $display("FAIL full_port_c%0d got=%b exp=00", c, {sp_rd_en, sp_wr_en}); end
            @(negedge clk);
        end
        sp_full = 1'b0;
        #1;
        total++; if (req_grant !== 4'b0001) begin bad++; $display("FAIL full_release got=%b exp=0001", req_grant); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_order_depth();
        int n;
        pulse_reset();
        n = 0;
        req_rd_en = 4'b0001;
        for (int c = 0; c < 32; c++) begin
            #1;
            if (req_grant === 4'b0001) n++;
            @(negedge clk);
        end
        total++; if (n != 32) begin bad++; $display("FAIL depth_fill got=%0d exp=32", n); end
        #1;
        total++; if (req_grant !== 4'b0000) begin bad++; $display("FAIL depth_block got=%b exp=0000", req_grant); end
        req_wr_en = 4'b0010;
        #1;
        total++; if (req_grant !== 4'b0010) begin bad++; $display("FAIL depth_write got=%b exp=0010", req_grant); end
        @(negedge clk);
        req_wr_en = '0;
        #1;
        total++; if (req_grant !== 4'b0000) begin bad++; $display("FAIL depth_block2 got=%b exp=0000", req_grant); end
        sp_valid = 1'b1; sp_q = 64'h55;
        #1;
        total++; if (req_grant !== 4'b0001 || rsp_valid !== 4'b0001) begin
            bad++; $display("FAIL depth_popush got=%b/%b exp=0001/0001", req_grant, rsp_valid); end
        @(posedge clk); #1;
        sp_valid = 1'b0;
        #1;
        total++; if (req_grant !== 4'b0000) begin bad++; $display("FAIL depth_refull got=%b exp=0000", req_grant); end
        idle_inputs();
    endtask

    task automatic test_stall();
        pulse_reset();
        req_rd_en = 4'b0010;
        #1;
        total++; if (req_grant !== 4'b0010) begin bad++; $display("FAIL stall_grant got=%b exp=0010", req_grant); end
        @(posedge clk); #1;
        req_rd_en = '0;
        sp_valid = 1'b1; sp_q = 64'h77; rsp_stall = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (sp_stall !== 1'b1 || rsp_valid !== 4'b0010) begin
                bad++; $display("FAIL stall_hold_c%0d got=%b/%b exp=1/0010", c, sp_stall, rsp_valid); end
            @(posedge clk); #1;
        end
        rsp_stall = '0;
        #1;
        total++; if (sp_stall !== 1'b0 || rsp_valid !== 4'b0010 || rsp_q !== 64'h77) begin
            bad++; $display("FAIL stall_release got=%b/%b/%h exp=0/0010/77", sp_stall, rsp_valid, rsp_q); end
        @(posedge clk); #1;
        sp_valid = 1'b0;
        total++; if (error !== 1'b0) begin bad++; $display("FAIL stall_error got=%b exp=0", error); end
    endtask

    task automatic test_rd_wr_priority();
        @(negedge clk);
        req_rd_en = 4'b1000; req_wr_en = 4'b1000;
        #1;
        total++; if (req_grant !== 4'b1000) begin bad++; $display("FAIL prio_grant got=%b exp=1000", req_grant); end
        @(posedge clk); #1;
        idle_inputs();
        total++; if (sp_wr_en !== 1'b1 || sp_rd_en !== 1'b0) begin
            bad++; $display("FAIL prio_port got=wr%b rd%b exp=wr1 rd0", sp_wr_en, sp_rd_en); end
    endtask

    task automatic test_error_reset();
        @(negedge clk);
        sp_valid = 1'b1; sp_q = 64'h99;
        #1;
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL err_rsp got=%b exp=0000", rsp_valid); end
        @(posedge clk); #1;
        sp_valid = 1'b0;
        total++; if (error !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", error); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (error !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", error); end
        pulse_reset();
        #1;
        total++; if (error !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", error); end
        req_wr_en = 4'b1111;
        #1;
        total++; if (req_grant !== 4'b0001) begin bad++; $display("FAIL err_rrptr got=%b exp=0001", req_grant); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_full();
        test_order_depth();
        test_stall();
        test_rd_wr_priority();
        test_error_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
